axil_reg_bank: RTL
==================

# axil_reg_bank

AXI4-Lite slave register bank that terminates the AXI-Lite master port of the I2C-to-AXI-Lite bridge. It holds the writable control registers that drive the acquisition and pulser logic, and it exposes read-only status words. Write and read channels are fully registered and handle independent AW/W arrival order. Every output is registered.

## Interface
- DATA_WIDTH, 32: data bus width; fixed at 32.
- ADDR_WIDTH, 16: byte address width.
- STRB_WIDTH, DATA_WIDTH/8: write-strobe width.
- NUM_REGS, 16: read/write control registers, word index 0..NUM_REGS-1.
- NUM_STATUS, 4: read-only status words, word index NUM_REGS..NUM_REGS+NUM_STATUS-1.
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- s_axil_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel; awprot is ignored.
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write data channel.
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axil_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel; arprot is ignored.
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; register i occupies bits [i*32 +: 32].
- reg_wr_pulse  out  NUM_REGS  one-cycle strobe per register on commit.
- status_in  in  NUM_STATUS*DATA_WIDTH  status words, sampled at the AR handshake.

## Operation
- Word index is addr[ADDR_WIDTH-1:2]. Bits [1:0] are ignored.
- Write path:
  - aw_held and w_held latch the address and the data/strobe independently.
  - awready = !aw_held && !bvalid. wready = !w_held && !bvalid.
  - Commit when aw_held && w_held && !bvalid:
    - For a valid RW index, write the bytes whose wstrb bit is set; all other bytes keep their value.
    - Pulse reg_wr_pulse[idx]. The pulse fires even when wstrb = 0.
    - Clear both held flags and set bvalid.
  - Writes to status indices or out-of-range indices change nothing and produce no pulse.
  - bvalid stays high until bready. Clear bvalid on the cycle where bvalid && bready.
- Read path:
  - arready = !rvalid.
  - On the AR handshake, rdata takes one of: register value (RW index), status_in word (status index), or 0 (out-of-range index). rvalid is set.
  - rvalid stays high until rready.
- Same cycle AR handshake and write commit to the same register: rdata returns the old value.
- Write and read channels run concurrently and do not block each other.
- bresp and rresp are OKAY (2'b00) except as stated under Configuration.

## Timing
- Reset values (asynchronous, on rst = 0):
  - All registers = 0, reg_out = 0, reg_wr_pulse = 0.
  - bvalid = 0, rvalid = 0, rdata = 0, bresp = 0, rresp = 0.
  - aw_held = 0 and w_held = 0, so awready = wready = arready = 1 immediately after reset release.
- AW and W handshakes at edge N: commit at edge N+1. reg_out updates, reg_wr_pulse and bvalid are high in the cycle after N+1.
- AW at edge N, W at edge M > N: commit at M+1. The reverse order is symmetric.
- Back-to-back writes: the next AW/W can be accepted in the cycle after the bvalid && bready handshake.
- Read latency: rvalid is high in the cycle after the AR handshake edge. Throughput is one read per 2 cycles when rready is held high.
- reg_wr_pulse is exactly one cycle wide.
- Reset asserted mid-transaction discards any held AW/W and any pending B/R. No partial write survives.

## Configuration
- AXIL_SLVERR_EN defined:
  - Writes to status or out-of-range indices return bresp = 2'b10 (SLVERR).
  - Reads of out-of-range indices return rresp = 2'b10 with rdata = 0.
  - Reads of status indices stay OKAY.
- AXIL_SLVERR_EN undefined: all responses are OKAY. Data behaviour is identical in both cases.

## Test plan
- Reset: assert rst = 0 mid-write, then release -> all reg_out = 0, bvalid = rvalid = 0, awready = wready = arready = 1.
- Write addr 0x0008 data 0xDEADBEEF strb 0xF, AW and W in the same cycle -> reg_out[2] = 0xDEADBEEF. reg_wr_pulse[2] is high for 1 cycle together with bvalid, one edge after the handshake. bresp = 0.
- W 3 cycles before AW, addr 0x0004 data 0x11223344 strb 0x5 over old value 0xAAAAAAAA -> reg 1 = 0xAA22AA44.
- Read addr 0x0040 with status_in word0 = 0x12345678 and NUM_REGS = 16 -> rdata = 0x12345678, rresp = 0, rvalid one cycle after the AR handshake. Hold rready = 0 for 5 cycles -> rvalid and rdata stay stable and arready stays 0.
- Write to addr 0x0050 (out of range) -> no register change, no pulse. bresp = 2'b10 with AXIL_SLVERR_EN, 2'b00 without. Read of the same address -> rdata = 0.
- Same-cycle AR handshake to addr 0x0000 and write commit of 0x5 to reg 0 (old value 0x3) -> rdata = 0x3, then a later read returns 0x5.

Source files
------------

// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS read/write control words plus NUM_STATUS read-only status words.
// Optional AXIL_SLVERR_EN: SLVERR on writes to non-RW indices and on reads of out-of-range indices.
module axil_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_REGS   = 16,
  parameter int NUM_STATUS = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            s_axil_awaddr,
  input  logic                             s_axil_awvalid,
  output logic                             s_axil_awready,
  input  logic [DATA_WIDTH-1:0]            s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]            s_axil_wstrb,
  input  logic                             s_axil_wvalid,
  output logic                             s_axil_wready,
  output logic [1:0]                       s_axil_bresp,
  output logic                             s_axil_bvalid,
  input  logic                             s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axil_araddr,
  input  logic                             s_axil_arvalid,
  output logic                             s_axil_arready,
  output logic [DATA_WIDTH-1:0]            s_axil_rdata,
  output logic [1:0]                       s_axil_rresp,
  output logic                             s_axil_rvalid,
  input  logic                             s_axil_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]              reg_wr_pulse,
  input  logic [NUM_STATUS*DATA_WIDTH-1:0] status_in
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                           aw_held_q, aw_held_d;
  logic [IDX_W-1:0]               aw_idx_q, aw_idx_d;
  logic                           w_held_q, w_held_d;
  logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]          wstrb_q, wstrb_d;
  logic                           bvalid_q, bvalid_d;
  logic [1:0]                     bresp_q, bresp_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            pulse_q, pulse_d;
  logic                           rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]          rdata_q, rdata_d;
  logic [1:0]                     rresp_q, rresp_d;
  logic                           commit;
  logic [IDX_W-1:0]               ar_idx;
  logic                           unused_addr_bits;

  // Handshakes: a transfer happens on a posedge where valid and ready are both high;
  // valid never depends on ready, and ready is derived only from held/pending flops.
  assign s_axil_awready = !aw_held_q && !bvalid_q;
  assign s_axil_wready  = !w_held_q && !bvalid_q;
  assign s_axil_arready = !rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_out        = regs_q;
  assign reg_wr_pulse   = pulse_q;

  assign ar_idx           = s_axil_araddr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    pulse_d   = '0;
    commit    = aw_held_q && w_held_q && !bvalid_q;

    if (bvalid_q && s_axil_bready) bvalid_d = 1'b0;
    if (s_axil_awvalid && s_axil_awready) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axil_awaddr[ADDR_WIDTH-1:2];
    end
    if (s_axil_wvalid && s_axil_wready) begin
      w_held_d = 1'b1;
      wdata_d  = s_axil_wdata;
      wstrb_d  = s_axil_wstrb;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_OKAY;
      // Pulse fires on any commit to an RW index, even with an all-zero strobe.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (aw_idx_q == IDX_W'(i)) begin
          pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_q[b]) regs_d[i*DATA_WIDTH + b*8 +: 8] = wdata_q[b*8 +: 8];
          end
        end
      end
`ifdef AXIL_SLVERR_EN
      if (aw_idx_q >= IDX_W'(NUM_REGS)) bresp_d = RESP_SLVERR;
`endif
    end
  end

  // Read mux samples regs_q, so a same-cycle commit is not visible to this read.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && s_axil_rready) rvalid_d = 1'b0;
    if (s_axil_arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ar_idx == IDX_W'(i)) rdata_d = regs_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int j = 0; j < NUM_STATUS; j++) begin
        if (ar_idx == IDX_W'(NUM_REGS + j)) rdata_d = status_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
`ifdef AXIL_SLVERR_EN
      if (ar_idx >= IDX_W'(NUM_REGS + NUM_STATUS)) rresp_d = RESP_SLVERR;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      regs_q    <= '0;
      pulse_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
      pulse_q   <= pulse_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
